// File: rtl/ssd_pkg.sv
// Shared types and seven-segment codes for the scanned display counter.
// Patterns are active-low {a,b,c,d,e,f,g,dp}; dp is always off.
package ssd_pkg;

  typedef logic [7:0] seg_t;
  typedef logic [3:0] digit_t;

  localparam seg_t SEG_0     = 8'b0000_0011;
  localparam seg_t SEG_1     = 8'b1001_1111;
  localparam seg_t SEG_2     = 8'b0010_0101;
  localparam seg_t SEG_3     = 8'b0000_1101;
  localparam seg_t SEG_4     = 8'b1001_1001;
  localparam seg_t SEG_5     = 8'b0100_1001;
  localparam seg_t SEG_6     = 8'b0100_0001;
  localparam seg_t SEG_7     = 8'b0001_1111;
  localparam seg_t SEG_8     = 8'b0000_0001;
  localparam seg_t SEG_9     = 8'b0000_1001;
  localparam seg_t SEG_A     = 8'b0001_0001;
  localparam seg_t SEG_B     = 8'b1100_0001;
  localparam seg_t SEG_C     = 8'b0110_0011;
  localparam seg_t SEG_D     = 8'b1000_0101;
  localparam seg_t SEG_E     = 8'b0110_0001;
  localparam seg_t SEG_F     = 8'b0111_0001;
  localparam seg_t SEG_BLANK = 8'b1111_1111;

  function automatic seg_t seg_decode(input logic [3:0] digit);
    seg_t res;
    res = SEG_BLANK;
    case (digit)
      4'h0: res = SEG_0;
      4'h1: res = SEG_1;
      4'h2: res = SEG_2;
      4'h3: res = SEG_3;
      4'h4: res = SEG_4;
      4'h5: res = SEG_5;
      4'h6: res = SEG_6;
      4'h7: res = SEG_7;
      4'h8: res = SEG_8;
      4'h9: res = SEG_9;
      4'hA: res = SEG_A;
      4'hB: res = SEG_B;
      4'hC: res = SEG_C;
      4'hD: res = SEG_D;
      4'hE: res = SEG_E;
      4'hF: res = SEG_F;
      default: res = SEG_BLANK;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ssd_digit_cnt.sv
// One up/down counter digit of configurable radix with synchronous clamped load.
// cout is combinational so a whole row of digits steps within a single clock.
module ssd_digit_cnt
  import ssd_pkg::*;
#(
  parameter int RADIX = 10
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   step,
  input  logic   up,
  input  logic   load,
  input  digit_t din,
  output digit_t q,
  output logic   cout
);

  localparam digit_t MAX = digit_t'(RADIX - 1);

  logic at_limit;

  assign at_limit = up ? (q == MAX) : (q == '0);
  assign cout     = step & at_limit;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= (din > MAX) ? MAX : din;
    end else if (step) begin
      if (up) q <= at_limit ? '0 : q + 1'b1;
      else    q <= at_limit ? MAX : q - 1'b1;
    end
  end

endmodule

// File: rtl/ssd_scan_counter.sv
// Multi-digit up/down counter with prescaler, digit scanner, leading-zero
// blanking and registered common-anode seven-segment outputs.
module ssd_scan_counter
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int RADIX      = 10,
  parameter int COUNT_DIV  = 100_000_000,
  parameter int SCAN_DIV   = 100_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    up,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   position,
  output logic [7:0]              pattern,
  output logic                    wrap
);

  localparam int PW = $clog2(COUNT_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [PW-1:0]           presc;
  logic                    tick;
  logic [NUM_DIGITS:0]     carry;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [SW-1:0]           slot;
  logic [IW-1:0]           index;
  logic [NUM_DIGITS-1:0]   lead_zero;
  logic                    all_zero;
  digit_t                  sel_digit;
  logic                    sel_blank;

  assign tick = en && (presc == PW'(COUNT_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       presc <= '0;
    else if (load)    presc <= '0;
    else if (tick)    presc <= '0;
    else if (en)      presc <= presc + 1'b1;
  end

  // The tick enters digit 0; each digit's carry/borrow steps the next one.
  assign carry[0] = tick;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    ssd_digit_cnt #(.RADIX(RADIX)) u_digit (
      .clk   (clk),
      .rst_n (rst_n),
      .step  (carry[g]),
      .up    (up),
      .load  (load),
      .din   (load_val[4*g +: 4]),
      .q     (digits[4*g +: 4]),
      .cout  (carry[g+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wrap <= 1'b0;
    else        wrap <= carry[NUM_DIGITS] & ~load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot  <= '0;
      index <= '0;
    end else if (slot == SW'(SCAN_DIV - 1)) begin
      slot  <= '0;
      index <= (index == IW'(NUM_DIGITS - 1)) ? '0 : index + 1'b1;
    end else begin
      slot  <= slot + 1'b1;
    end
  end

  // NOTE: every variable gets a default before the loops so no latch is inferred.
  always_comb begin
    lead_zero = '0;
    all_zero  = 1'b1;
    sel_digit = '0;
    sel_blank = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero     = all_zero & (digits[4*i +: 4] == 4'd0);
      lead_zero[i] = all_zero;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (index == IW'(i)) begin
        sel_digit = digits[4*i +: 4];
        sel_blank = blank_lz && (i != 0) && lead_zero[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      position <= ~NUM_DIGITS'(1);
      pattern  <= SEG_0;
    end else begin
      position <= ~(NUM_DIGITS'(1) << index);
      pattern  <= sel_blank ? SEG_BLANK : seg_decode(sel_digit);
    end
  end

endmodule

// File: tb/tb_ssd_scan_counter.sv
// Self-checking bench: 2-digit BCD counter, COUNT_DIV=4, SCAN_DIV=2.
// A behavioural model feeds a scoreboard queue; a vector table checks load/blanking display.
module tb_ssd_scan_counter;

  logic       clk = 1'b0;
  logic       rst_n, en, up, load, blank_lz;
  logic [7:0] load_val;
  logic [1:0] position;
  logic [7:0] pattern;
  logic       wrap;

  always #5 clk = ~clk;

  ssd_scan_counter #(
    .NUM_DIGITS(2), .RADIX(10), .COUNT_DIV(4), .SCAN_DIV(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .blank_lz (blank_lz),
    .position (position),
    .pattern  (pattern),
    .wrap     (wrap)
  );

  typedef struct {
    logic [1:0] pos;
    logic [7:0] pat;
    logic       wrap;
  } exp_t;

  typedef struct {
    logic [7:0] lv;
    logic       blank;
    logic [7:0] exp_hi;
    logic [7:0] exp_lo;
  } vec_t;

  exp_t       sb[$];
  vec_t       vecs[7];
  logic [7:0] seg_tab[10];
  int         errors = 0;
  int         checks = 0;
  int         m_val, m_presc, m_slot, m_idx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_pat(input int idx, input int val, input logic b);
    if (idx == 1) begin
      if (b && (val / 10) == 0) return 8'hFF;
      return seg_tab[val / 10];
    end
    return seg_tab[val % 10];
  endfunction

  // One clock: drive at negedge, predict, then compare 1 time unit after the posedge.
  task automatic cycle(input logic e, input logic u, input logic l,
                       input logic [7:0] lv, input logic b);
    exp_t x;
    exp_t got;
    int   d1, d0;
    @(negedge clk);
    en = e; up = u; load = l; load_val = lv; blank_lz = b;
    x.pos  = (m_idx == 0) ? 2'b10 : 2'b01;
    x.pat  = model_pat(m_idx, m_val, b);
    x.wrap = 1'b0;
    if (l) begin
      d1 = int'(lv[7:4]); if (d1 > 9) d1 = 9;
      d0 = int'(lv[3:0]); if (d0 > 9) d0 = 9;
      m_val   = d1 * 10 + d0;
      m_presc = 0;
    end else if (e && m_presc == 3) begin
      if (u) begin
        x.wrap = (m_val == 99);
        m_val  = (m_val + 1) % 100;
      end else begin
        x.wrap = (m_val == 0);
        m_val  = (m_val + 99) % 100;
      end
      m_presc = 0;
    end else if (e) begin
      m_presc++;
    end
    if (m_slot == 1) begin
      m_slot = 0;
      m_idx  = (m_idx + 1) % 2;
    end else begin
      m_slot++;
    end
    sb.push_back(x);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check("sb_position", 32'(position), 32'(got.pos));
    check("sb_pattern",  32'(pattern),  32'(got.pat));
    check("sb_wrap",     32'(wrap),     32'(got.wrap));
  endtask

  task automatic model_reset();
    m_val = 0; m_presc = 0; m_slot = 0; m_idx = 0;
    sb.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int wrap_at, wrap_n, guard;
    logic [7:0] got_hi, got_lo;

    seg_tab[0] = 8'b0000_0011; seg_tab[1] = 8'b1001_1111;
    seg_tab[2] = 8'b0010_0101; seg_tab[3] = 8'b0000_1101;
    seg_tab[4] = 8'b1001_1001; seg_tab[5] = 8'b0100_1001;
    seg_tab[6] = 8'b0100_0001; seg_tab[7] = 8'b0001_1111;
    seg_tab[8] = 8'b0000_0001; seg_tab[9] = 8'b0000_1001;

    vecs[0] = '{8'h3C, 1'b0, 8'b0000_1101, 8'b0000_1001};
    vecs[1] = '{8'h05, 1'b1, 8'b1111_1111, 8'b0100_1001};
    vecs[2] = '{8'h05, 1'b0, 8'b0000_0011, 8'b0100_1001};
    vecs[3] = '{8'hFF, 1'b0, 8'b0000_1001, 8'b0000_1001};
    vecs[4] = '{8'h00, 1'b1, 8'b1111_1111, 8'b0000_0011};
    vecs[5] = '{8'h70, 1'b1, 8'b0001_1111, 8'b0000_0011};
    vecs[6] = '{8'h82, 1'b1, 8'b0000_0001, 8'b0010_0101};

    rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00; blank_lz = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check("reset_position", 32'(position), 32'(2'b10));
    check("reset_pattern",  32'(pattern),  32'(8'b0000_0011));
    check("reset_wrap",     32'(wrap),     32'(1'b0));
    rst_n = 1'b1;

    for (int k = 0; k < 6; k++) cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);

    // Up wrap: 98 -> 99 four cycles after load, -> 00 with wrap four cycles later.
    cycle(1'b1, 1'b1, 1'b1, 8'h98, 1'b0);
    wrap_at = -1; wrap_n = 0;
    for (int k = 1; k <= 10; k++) begin
      cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      if (wrap === 1'b1) begin
        wrap_n++;
        if (wrap_at < 0) wrap_at = k;
      end
    end
    check("up_wrap_cycle", 32'(wrap_at), 32'(8));
    check("up_wrap_width", 32'(wrap_n),  32'(1));

    // Down: 10 -> 09, then 00 -> 99 with wrap on the first tick.
    cycle(1'b1, 1'b0, 1'b1, 8'h10, 1'b0);
    for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
    wrap_at = -1;
    for (int k = 1; k <= 6; k++) begin
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      if (wrap === 1'b1 && wrap_at < 0) wrap_at = k;
    end
    check("down_wrap_cycle", 32'(wrap_at), 32'(4));

    // Load on a tick cycle at 99 counting up: load wins, no wrap, clamp C->9.
    cycle(1'b1, 1'b1, 1'b1, 8'h99, 1'b0);
    guard = 0;
    while (m_presc != 3 && guard < 8) begin
      cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      guard++;
    end
    check("load_prio_align", 32'(m_presc), 32'(3));
    cycle(1'b1, 1'b1, 1'b1, 8'h3C, 1'b0);
    check("load_prio_nowrap", 32'(wrap), 32'(1'b0));
    for (int k = 0; k < 6; k++) cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);

    // Enable hold mid-period: count and prescaler freeze, scanning continues.
    for (int k = 0; k < 2; k++)  cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 10; k++) cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 8; k++)  cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);

    // Vector table: loaded value and blanking as seen in each digit slot.
    for (int v = 0; v < 7; v++) begin
      cycle(1'b0, 1'b1, 1'b1, vecs[v].lv, vecs[v].blank);
      cycle(1'b0, 1'b1, 1'b0, 8'h00, vecs[v].blank);
      got_hi = 8'hxx; got_lo = 8'hxx;
      for (int k = 0; k < 4; k++) begin
        cycle(1'b0, 1'b1, 1'b0, 8'h00, vecs[v].blank);
        if (position === 2'b01) got_hi = pattern;
        if (position === 2'b10) got_lo = pattern;
      end
      check("vec_digit1", 32'(got_hi), 32'(vecs[v].exp_hi));
      check("vec_digit0", 32'(got_lo), 32'(vecs[v].exp_lo));
    end

    // Asynchronous reset in the middle of counting.
    cycle(1'b1, 1'b1, 1'b1, 8'h47, 1'b0);
    for (int k = 0; k < 5; k++) cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midreset_position", 32'(position), 32'(2'b10));
    check("midreset_pattern",  32'(pattern),  32'(8'b0000_0011));
    check("midreset_wrap",     32'(wrap),     32'(1'b0));
    model_reset();
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
